regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 195 +++++++++++++++++++
 tb/tb_regfile_param.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Parameterised register file with two write ports (A and B), two
// combinational read ports and a self-timed clear sweep.
//
// After reset release, and after every accepted clear request, a sweep walks a
// pointer over every register and writes zero, one register per clock edge.
// While the sweep runs, busy is high, writes are dropped and both read ports
// return zero. Outside the sweep, port B wins when both ports write the same
// address. Optional behaviours:
//   ZERO_REG = 1 : register 0 is hard-wired to zero (writes discarded).
//   BYPASS   = 1 : same-cycle write data is forwarded to matching read ports.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width; the file holds 2**ADDR_W registers
//   ZERO_REG  1 = register 0 reads 0 and ignores writes
//   BYPASS    1 = forward same-cycle write data to the read ports
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   reset               asynchronous, active-high reset (restarts the sweep)
//   clear               synchronous request to zero the whole file
//   RegWrite/WriteReg/WriteData     write port A
//   RegWrite2/WriteReg2/WriteData2  write port B
//   ReadReg1/ReadData1  read port 1 (combinational)
//   ReadReg2/ReadData2  read port 2 (combinational)
//   busy                high while the clear sweep is in progress
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite2,
    input  logic [ADDR_W-1:0] WriteReg2,
    input  logic [DATA_W-1:0] WriteData2,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              busy
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              we_a;
    logic              we_b;

    // -------------------------------------------------------------------------
    // Write qualification: writes only land outside the sweep, and register 0
    // swallows them when it is hard-wired to zero.
    // -------------------------------------------------------------------------
    always_comb begin
        we_a = (state_q == IDLE) && RegWrite
               && !((ZERO_REG != 0) && (WriteReg == '0));
        we_b = (state_q == IDLE) && RegWrite2
               && !((ZERO_REG != 0) && (WriteReg2 == '0));
    end

    // -------------------------------------------------------------------------
    // Control: next-state logic for the sweep/idle machine.
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            SWEEP: begin
                // clear is ignored here; the sweep never restarts early.
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear) begin
                    ptr_d   = '0;
                    state_d = SWEEP;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
        // busy is registered so it tracks the state it will be in after the edge.
        busy_d = (state_d == SWEEP);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage. The sweep owns the array while it runs; otherwise the write
    // ports do. A clear accepted in IDLE still lets that edge's writes land;
    // the sweep that follows zeroes them.
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch on purpose; it is zeroed only by the
    // sweep, which keeps it mappable onto plain RAM without per-bit resets.
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) begin
            regs[ptr_q] <= '0;
        end else begin
            if (we_a) begin
                regs[WriteReg] <= WriteData;
            end
            // Port B is assigned last, so it wins an address collision.
            if (we_b) begin
                regs[WriteReg2] <= WriteData2;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: stored value, optionally overridden by same-cycle write data
    // (port B over port A), then forced to zero for the hard-wired register and
    // for the whole sweep (including while reset is asserted).
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_a,
        input logic [ADDR_W-1:0] waddr_a,
        input logic [DATA_W-1:0] wdata_a,
        input logic              fwd_b,
        input logic [ADDR_W-1:0] waddr_b,
        input logic [DATA_W-1:0] wdata_b,
        input logic              sweeping
    );
        logic [DATA_W-1:0] rd;
        rd = stored;
        if (BYPASS != 0) begin
            if (fwd_a && (waddr_a == addr)) begin
                rd = wdata_a;
            end
            if (fwd_b && (waddr_b == addr)) begin
                rd = wdata_b;
            end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            rd = '0;
        end
        if (sweeping) begin
            rd = '0;
        end
        return rd;
    endfunction

    always_comb begin
        ReadData1 = read_mux(ReadReg1, regs[ReadReg1],
                             we_a, WriteReg, WriteData,
                             we_b, WriteReg2, WriteData2,
                             state_q == SWEEP);
        ReadData2 = read_mux(ReadReg2, regs[ReadReg2],
                             we_a, WriteReg, WriteData,
                             we_b, WriteReg2, WriteData2,
                             state_q == SWEEP);
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//
// Drives two instances of regfile_param side by side:
//   u_dut_a : DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1 (defaults)
//   u_dut_b : DATA_W=8,  ADDR_W=3, ZERO_REG=0, BYPASS=0
// Inputs change on the falling edge; outputs are compared 1 ns later against
// a reference model that tracks register contents in plain arrays and the
// sweep as a count of remaining edges.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    localparam int NUM_A = 32;
    localparam int NUM_B = 8;

    logic clk;
    logic reset;

    // Instance A signals
    logic        clear_a;
    logic        we1_a, we2_a;
    logic [4:0]  wa1_a, wa2_a, ra1_a, ra2_a;
    logic [31:0] wd1_a, wd2_a, rd1_a, rd2_a;
    logic        busy_a;

    // Instance B signals
    logic        clear_b;
    logic        we1_b, we2_b;
    logic [2:0]  wa1_b, wa2_b, ra1_b, ra2_b;
    logic [7:0]  wd1_b, wd2_b, rd1_b, rd2_b;
    logic        busy_b;

    // Reference model
    logic [31:0] mem_a [NUM_A];
    logic [7:0]  mem_b [NUM_B];
    int          sweep_a;
    int          sweep_b;

    int n_checks;
    int n_errors;

    regfile_param u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_a),
        .RegWrite   (we1_a),
        .WriteReg   (wa1_a),
        .WriteData  (wd1_a),
        .RegWrite2  (we2_a),
        .WriteReg2  (wa2_a),
        .WriteData2 (wd2_a),
        .ReadReg1   (ra1_a),
        .ReadReg2   (ra2_a),
        .ReadData1  (rd1_a),
        .ReadData2  (rd2_a),
        .busy       (busy_a)
    );

    regfile_param #(
        .DATA_W   (8),
        .ADDR_W   (3),
        .ZERO_REG (0),
        .BYPASS   (0)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_b),
        .RegWrite   (we1_b),
        .WriteReg   (wa1_b),
        .WriteData  (wd1_b),
        .RegWrite2  (we2_b),
        .WriteReg2  (wa2_b),
        .WriteData2 (wd2_b),
        .ReadReg1   (ra1_b),
        .ReadReg2   (ra2_b),
        .ReadData1  (rd1_b),
        .ReadData2  (rd2_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected read value for A: hard-wired zero register, bypass with B first.
    function automatic logic [31:0] exp_a(input logic [4:0] addr);
        if (sweep_a > 0) return 32'h0;
        if (addr == 5'd0) return 32'h0;
        if (we2_a && wa2_a == addr) return wd2_a;
        if (we1_a && wa1_a == addr) return wd1_a;
        return mem_a[addr];
    endfunction

    // Expected read value for B: no bypass, register 0 ordinary.
    function automatic logic [7:0] exp_b(input logic [2:0] addr);
        if (sweep_b > 0) return 8'h0;
        return mem_b[addr];
    endfunction

    task automatic idle_inputs();
        clear_a = 1'b0; we1_a = 1'b0; we2_a = 1'b0;
        wa1_a = '0; wa2_a = '0; wd1_a = '0; wd2_a = '0; ra1_a = '0; ra2_a = '0;
        clear_b = 1'b0; we1_b = 1'b0; we2_b = 1'b0;
        wa1_b = '0; wa2_b = '0; wd1_b = '0; wd2_b = '0; ra1_b = '0; ra2_b = '0;
    endtask

    task automatic check_outputs();
        check("rd1_a", rd1_a, exp_a(ra1_a));
        check("rd2_a", rd2_a, exp_a(ra2_a));
        check("busy_a", {31'b0, busy_a}, {31'b0, sweep_a > 0});
        check("rd1_b", {24'b0, rd1_b}, {24'b0, exp_b(ra1_b)});
        check("rd2_b", {24'b0, rd2_b}, {24'b0, exp_b(ra2_b)});
        check("busy_b", {31'b0, busy_b}, {31'b0, sweep_b > 0});
    endtask

    // Apply one rising edge to the model using the inputs held across it.
    task automatic update_models();
        if (reset) begin
            sweep_a = NUM_A;
            sweep_b = NUM_B;
        end else begin
            if (sweep_a > 0) begin
                sweep_a--;
                if (sweep_a == 0) foreach (mem_a[i]) mem_a[i] = '0;
            end else begin
                if (we1_a && wa1_a != 5'd0) mem_a[wa1_a] = wd1_a;
                if (we2_a && wa2_a != 5'd0) mem_a[wa2_a] = wd2_a;
                if (clear_a) sweep_a = NUM_A;
            end
            if (sweep_b > 0) begin
                sweep_b--;
                if (sweep_b == 0) foreach (mem_b[i]) mem_b[i] = '0;
            end else begin
                if (we1_b) mem_b[wa1_b] = wd1_b;
                if (we2_b) mem_b[wa2_b] = wd2_b;
                if (clear_b) sweep_b = NUM_B;
            end
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        update_models();
        @(negedge clk);
    endtask

    // Counts busy samples (one per cycle) over a bounded window. At cycle 3 a
    // write is attempted on both instances; it must be dropped if sweeping.
    task automatic count_sweep(input bit try_write, output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            idle_inputs();
            if (try_write && i == 3) begin
                we1_a = 1'b1; wa1_a = 5'd8; wd1_a = 32'h99; ra1_a = 5'd8;
                we1_b = 1'b1; wa1_b = 3'd2; wd1_b = 8'h77; ra1_b = 3'd2;
            end
            if (busy_a) na++;
            if (busy_b) nb++;
            cycle();
        end
    endtask

    int na, nb;

    initial begin
        n_checks = 0;
        n_errors = 0;
        foreach (mem_a[i]) mem_a[i] = '0;
        foreach (mem_b[i]) mem_b[i] = '0;
        idle_inputs();
        reset   = 1'b1;
        sweep_a = NUM_A;
        sweep_b = NUM_B;

        // Held in reset across a couple of edges.
        @(negedge clk);
        cycle();
        cycle();

        // Release: sweep lengths, then every register reads 0.
        reset = 1'b0;
        count_sweep(1'b0, na, nb);
        check("sweep_len_a_rst", na, 32);
        check("sweep_len_b_rst", nb, 8);
        for (int i = 0; i < NUM_A; i++) begin
            idle_inputs();
            ra1_a = 5'(i); ra2_a = 5'(31 - i);
            ra1_b = 3'(i); ra2_b = 3'(7 - i);
            cycle();
        end

        // Port A write to reg 8 with same-cycle read; B: reg 7, no bypass.
        idle_inputs();
        we1_a = 1'b1; wa1_a = 5'd8; wd1_a = 32'h0000000A; ra1_a = 5'd8;
        we1_b = 1'b1; wa1_b = 3'd7; wd1_b = 8'h0A;        ra1_b = 3'd7;
        #1;
        check("bypass_same_cycle_a", rd1_a, 32'd10);
        check("no_bypass_old_b", {24'b0, rd1_b}, 32'd0);
        cycle();
        idle_inputs();
        ra1_a = 5'd8; ra1_b = 3'd7;
        #1;
        check("readback_a_r8", rd1_a, 32'd10);
        check("readback_b_r7", {24'b0, rd1_b}, 32'd10);
        cycle();

        // Both ports write the same register: B wins (A reg 9, B reg 5).
        idle_inputs();
        we1_a = 1'b1; wa1_a = 5'd9; wd1_a = 32'd20;
        we2_a = 1'b1; wa2_a = 5'd9; wd2_a = 32'd22; ra1_a = 5'd9;
        we1_b = 1'b1; wa1_b = 3'd5; wd1_b = 8'd20;
        we2_b = 1'b1; wa2_b = 3'd5; wd2_b = 8'd22; ra1_b = 3'd5;
        #1;
        check("collide_bypass_a", rd1_a, 32'd22);
        cycle();
        idle_inputs();
        ra1_a = 5'd9; ra1_b = 3'd5;
        #1;
        check("collide_a_r9", rd1_a, 32'd22);
        check("collide_b_r5", {24'b0, rd1_b}, 32'd22);
        cycle();

        // Register 0: hard-wired on A, ordinary on B.
        idle_inputs();
        we1_a = 1'b1; wa1_a = 5'd0; wd1_a = 32'hFFFFFFFF; ra1_a = 5'd0;
        we2_b = 1'b1; wa2_b = 3'd0; wd2_b = 8'h55;        ra2_b = 3'd0;
        #1;
        check("zero_reg_bypass_a", rd1_a, 32'd0);
        cycle();
        idle_inputs();
        ra1_a = 5'd0; ra2_b = 3'd0;
        #1;
        check("zero_reg_a", rd1_a, 32'd0);
        check("reg0_b", {24'b0, rd2_b}, 32'h55);
        cycle();

        // Load A regs 8..15 with 10..80 (both ports), B regs 0..7 likewise.
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            we1_a = 1'b1; wa1_a = 5'(8 + 2 * i); wd1_a = 32'(10 * (2 * i + 1));
            we2_a = 1'b1; wa2_a = 5'(9 + 2 * i); wd2_a = 32'(10 * (2 * i + 2));
            we1_b = 1'b1; wa1_b = 3'(2 * i);     wd1_b = 8'(10 * (2 * i + 1));
            we2_b = 1'b1; wa2_b = 3'(2 * i + 1); wd2_b = 8'(10 * (2 * i + 2));
            cycle();
        end
        idle_inputs();
        ra1_a = 5'd15; ra2_a = 5'd12; ra1_b = 3'd7;
        #1;
        check("loaded_a_r15", rd1_a, 32'd80);
        check("loaded_a_r12", rd2_a, 32'd50);
        check("loaded_b_r7", {24'b0, rd1_b}, 32'd80);
        cycle();

        // Clear together with a write: write lands, then the sweep zeroes it.
        idle_inputs();
        clear_a = 1'b1; we1_a = 1'b1; wa1_a = 5'd20; wd1_a = 32'h1234;
        clear_b = 1'b1;
        cycle();
        count_sweep(1'b1, na, nb);
        check("sweep_len_a_clr", na, 32);
        check("sweep_len_b_clr", nb, 8);
        for (int i = 8; i < 16; i++) begin
            idle_inputs();
            ra1_a = 5'(i); ra2_a = 5'd20; ra1_b = 3'(i - 8); ra2_b = 3'd2;
            #1;
            check("cleared_a", rd1_a, 32'd0);
            check("cleared_b", {24'b0, rd1_b}, 32'd0);
            cycle();
        end

        // Reset at sweep cycle 10 of A while B holds a readable value.
        idle_inputs();
        we1_b = 1'b1; wa1_b = 3'd3; wd1_b = 8'hAB;
        cycle();
        idle_inputs();
        clear_a = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            ra1_b = 3'd3;
            cycle();
        end
        idle_inputs();
        ra1_b = 3'd3;
        #1;
        check("pre_reset_b_r3", {24'b0, rd1_b}, 32'hAB);
        #1;
        reset = 1'b1;
        sweep_a = NUM_A;
        sweep_b = NUM_B;
        #1;
        check("async_busy_a", {31'b0, busy_a}, 32'd1);
        check("async_busy_b", {31'b0, busy_b}, 32'd1);
        check("async_rd_b", {24'b0, rd1_b}, 32'd0);
        @(posedge clk);
        update_models();
        @(negedge clk);
        cycle();
        reset = 1'b0;
        count_sweep(1'b0, na, nb);
        check("sweep_len_a_rst2", na, 32);
        check("sweep_len_b_rst2", nb, 8);

        // Address 7 on B and the top address on A.
        idle_inputs();
        we1_b = 1'b1; wa1_b = 3'd7; wd1_b = 8'hC3;
        we1_a = 1'b1; wa1_a = 5'd31; wd1_a = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        ra2_b = 3'd7; ra2_a = 5'd31;
        #1;
        check("addr7_b", {24'b0, rd2_b}, 32'hC3);
        check("addr31_a", rd2_a, 32'hDEADBEEF);
        cycle();

        // Randomised traffic with occasional clear and reset.
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            we1_a = 1'($urandom_range(0, 1));
            we2_a = 1'($urandom_range(0, 1));
            wa1_a = 5'($urandom_range(0, 31));
            wa2_a = ($urandom_range(0, 3) == 0) ? wa1_a : 5'($urandom_range(0, 31));
            wd1_a = $urandom;
            wd2_a = $urandom;
            ra1_a = ($urandom_range(0, 1) == 0) ? wa1_a : 5'($urandom_range(0, 31));
            ra2_a = ($urandom_range(0, 1) == 0) ? wa2_a : 5'($urandom_range(0, 31));
            clear_a = ($urandom_range(0, 59) == 0);
            we1_b = 1'($urandom_range(0, 1));
            we2_b = 1'($urandom_range(0, 1));
            wa1_b = 3'($urandom_range(0, 7));
            wa2_b = ($urandom_range(0, 3) == 0) ? wa1_b : 3'($urandom_range(0, 7));
            wd1_b = 8'($urandom);
            wd2_b = 8'($urandom);
            ra1_b = ($urandom_range(0, 1) == 0) ? wa1_b : 3'($urandom_range(0, 7));
            ra2_b = 3'($urandom_range(0, 7));
            clear_b = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 249) == 0) begin
                reset   = 1'b1;
                sweep_a = NUM_A;
                sweep_b = NUM_B;
            end else begin
                reset = 1'b0;
            end
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
